// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Fill FSM encoding and packed-port slice offsets.
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_st_e;

  function automatic int slice_lo(
    input int k,
    input int w
  );
    return k * w;
  endfunction

endpackage

// File: rtl/rf_fill_ctrl.sv
// Fill sequencer for the register file.
// Walks every writable register once with a captured value.
module rf_fill_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_init_req,
  input  logic [DATA_W-1:0] i_init_val,
  output logic              o_fill_we,
  output logic [ADDR_W-1:0] o_fill_addr,
  output logic [DATA_W-1:0] o_fill_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int IDX_W = ADDR_W + 1;

  // Extra index bit keeps the terminal compare from aliasing index 0.
  localparam logic [IDX_W-1:0] IDX_START =
    (ZERO_REG != 0) ? IDX_W'(1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(DEPTH - 1);

  fill_st_e          r_st;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_val;
  logic              r_busy;
  logic              r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st   <= ST_IDLE;
      r_idx  <= '0;
      r_val  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      unique case (r_st)
        ST_IDLE: begin
          if (i_init_req) begin
            r_st   <= ST_FILL;
            r_idx  <= IDX_START;
            r_val  <= i_init_val;
            r_busy <= 1'b1;
          end
        end
        ST_FILL: begin
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == IDX_LAST) begin
            r_st   <= ST_DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_st   <= ST_IDLE;
          r_done <= 1'b0;
        end
        default: begin
          r_st   <= ST_IDLE;
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_fill_we   = r_busy;
  assign o_fill_addr = r_idx[ADDR_W-1:0];
  assign o_fill_data = r_val;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with optional
// zero register, write bypass and a bulk fill sequencer.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     init_req,
  input  logic [DATA_W-1:0]        init_val,
  output logic                     init_busy,
  output logic                     init_done
);

  localparam int   DEPTH = 1 << ADDR_W;
  localparam logic ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_fill_we;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [DATA_W-1:0] w_fill_data;
  logic              w_lock;
  logic              w_wv0;
  logic              w_wv1;
  logic              w_fv;

  rf_fill_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_fill (
    .clk         (clk),
    .reset       (reset),
    .i_init_req  (init_req),
    .i_init_val  (init_val),
    .o_fill_we   (w_fill_we),
    .o_fill_addr (w_fill_addr),
    .o_fill_data (w_fill_data),
    .o_busy      (init_busy),
    .o_done      (init_done)
  );

  // A write that reset or the fill sequence will discard must
  // not be forwarded either.
  assign w_lock = init_busy | init_done;
  assign w_wv0  = we0 & ~w_lock & ~reset
                & ~(ZR & (waddr0 == '0));
  assign w_wv1  = we1 & ~w_lock & ~reset
                & ~(ZR & (waddr1 == '0));
  assign w_fv   = w_fill_we
                & ~(ZR & (w_fill_addr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_fv) r_mem[w_fill_addr] <= w_fill_data;
      if (w_wv0) r_mem[waddr0] <= wdata0;
      if (w_wv1) r_mem[waddr1] <= wdata1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rv;

    assign w_ra = rd_addr[slice_lo(g, ADDR_W) +: ADDR_W];

    always_comb begin
      w_rv = r_mem[w_ra];
      if (BYPASS != 0) begin
        if (w_wv0 && (waddr0 == w_ra)) w_rv = wdata0;
        if (w_wv1 && (waddr1 == w_ra)) w_rv = wdata1;
      end
      if (ZR && (w_ra == '0)) w_rv = '0;
    end

    assign rd_data[slice_lo(g, DATA_W) +: DATA_W] = w_rv;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp at default parameters.
// Hand-computed expectations checked with immediate asserts.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic        init_req;
  logic [31:0] init_val;
  logic        init_busy, init_done;

  int total = 0;
  int bad   = 0;
  int cnt;
  int dcnt;
  int guard;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .we0       (we0),
    .we1       (we1),
    .waddr0    (waddr0),
    .waddr1    (waddr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .init_req  (init_req),
    .init_val  (init_val),
    .init_busy (init_busy),
    .init_done (init_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ra(input int k, input logic [4:0] a);
    rd_addr[k*5 +: 5] = a;
  endtask

  function automatic logic [31:0] rd(input int k);
    return rd_data[k*32 +: 32];
  endfunction

  initial begin
    reset = 1'b1; rd_addr = '0;
    we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0;
    wdata0 = 0; wdata1 = 0;
    init_req = 0; init_val = 0;
    tick(); tick();
    reset = 1'b0;
    set_ra(0, 5'd3); set_ra(1, 5'd7);
    #1;
    chk("rst_r3", rd(0), 32'd0);
    chk("rst_r7", rd(1), 32'd0);
    chk("rst_busy", {31'd0, init_busy}, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);

    // single write + bypass
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'h0000_0005;
    #1 chk("byp_r3", rd(0), 32'd5);
    tick();
    we0 = 0; wdata0 = 32'h0;
    #1 chk("wr_r3", rd(0), 32'd5);

    // dual write collision, port 1 wins
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'd11;
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'd22;
    #1 chk("byp_r7", rd(1), 32'd22);
    tick();
    we0 = 0; we1 = 0;
    #1 chk("wr_r7", rd(1), 32'd22);
    chk("r3_kept", rd(0), 32'd5);

    // zero register
    set_ra(0, 5'd0);
    we1 = 1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
    #1 chk("byp_r0", rd(0), 32'd0);
    tick();
    we1 = 0;
    #1 chk("wr_r0", rd(0), 32'd0);

    // full fill with competing writes
    init_val = 32'hFFFF_FFCB; init_req = 1;
    tick();
    init_req = 0; init_val = 32'h0;
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'h1234;
    we1 = 1; waddr1 = 5'd9; wdata1 = 32'h5678;
    set_ra(0, 5'd5); set_ra(1, 5'd9);
    cnt = 0; dcnt = 0; guard = 0;
    #1;
    while (init_busy === 1'b1 && guard < 200) begin
      cnt++;
      if (init_done === 1'b1) dcnt++;
      tick();
      guard++;
    end
    chk("fill_busy_cycles", cnt, 31);
    chk("fill_done_in_busy", dcnt, 0);
    chk("fill_done_pulse", {31'd0, init_done}, 32'd1);
    chk("done_no_byp", rd(0), 32'hFFFF_FFCB);
    tick();
    we0 = 0; we1 = 0;
    #1 chk("done_fall", {31'd0, init_done}, 32'd0);
    chk("idle_busy", {31'd0, init_busy}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      set_ra(0, a[4:0]);
      #1 chk($sformatf("fill_r%0d", a), rd(0),
             (a == 0) ? 32'd0 : 32'hFFFF_FFCB);
    end

    // reset in the 10th fill cycle
    init_val = 32'hA5A5_A5A5; init_req = 1;
    tick();
    init_req = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("fill10_busy", {31'd0, init_busy}, 32'd1);
    reset = 1;
    tick();
    reset = 0;
    #1 chk("abort_busy", {31'd0, init_busy}, 32'd0);
    chk("abort_done", {31'd0, init_done}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      set_ra(1, a[4:0]);
      #1 chk($sformatf("abort_r%0d", a), rd(1), 32'd0);
    end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (init_done !== 1'b0 || init_busy !== 1'b0) dcnt++;
    end
    chk("abort_quiet", dcnt, 0);

    // reset beats simultaneous write
    we0 = 1; waddr0 = 5'd4; wdata0 = 32'h0000_DEAD;
    we1 = 1; waddr1 = 5'd6; wdata1 = 32'h0000_BEEF;
    tick();
    we1 = 0;
    set_ra(0, 5'd4); set_ra(1, 5'd6);
    wdata0 = 32'h0000_0777;
    #1 chk("pre_r6", rd(1), 32'h0000_BEEF);
    chk("pre_byp_r4", rd(0), 32'h0000_0777);
    reset = 1;
    tick();
    chk("rstw_r4", rd(0), 32'd0);
    chk("rstw_r6", rd(1), 32'd0);
    reset = 0; we0 = 0;
    #1 chk("post_r4", rd(0), 32'd0);
    chk("post_r6", rd(1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
